// File: rtl/core_datapath_pkg.sv
// Shared types and bit-index constants for the per-core datapath.
package core_datapath_pkg;

  localparam int REG_WIDTH_DEF = 12;
  localparam int IR_WIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    ALU_CLR  = 3'd0,
    ALU_PASS = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_MUL  = 3'd4,
    ALU_INC  = 3'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    BUS_DM = 4'd0,
    BUS_PC = 4'd1,
    BUS_IR = 4'd2,
    BUS_RL = 4'd3,
    BUS_RC = 4'd4,
    BUS_RP = 4'd5,
    BUS_RQ = 4'd6,
    BUS_R1 = 4'd7,
    BUS_AC = 4'd8,
    BUS_R  = 4'd9
  } bus_in_sel_t;

  typedef logic [9:0] wrEnReg_t;
  typedef logic [3:0] inc_reg_t;

  // wrEnReg packing is {AR, R, PC, IR, RL, RC, RP, RQ, R1, AC}
  localparam int WR_AR = 9;
  localparam int WR_R  = 8;
  localparam int WR_PC = 7;
  localparam int WR_IR = 6;
  localparam int WR_RL = 5;
  localparam int WR_RC = 4;
  localparam int WR_RP = 3;
  localparam int WR_RQ = 2;
  localparam int WR_R1 = 1;
  localparam int WR_AC = 0;

  // incReg packing is {PC, RC, RP, RQ}
  localparam int INC_PC = 3;
  localparam int INC_RC = 2;
  localparam int INC_RP = 1;
  localparam int INC_RQ = 0;

endpackage

// File: rtl/core_datapath_alu.sv
// Combinational ALU: A is the accumulator, B is the bus. Results wrap.
// ALU_OVF_FLAG_EN adds the unsigned overflow output ovf.
module core_datapath_alu
  import core_datapath_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  alu_op_t              op,
  output logic [REG_WIDTH-1:0] result
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic                 ovf
`endif
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  logic [REG_WIDTH-1:0] add_s;
  logic [REG_WIDTH-1:0] mul_lo;

`ifdef ALU_OVF_FLAG_EN
  logic                 add_c;
  logic [REG_WIDTH-1:0] mul_hi;

  assign {add_c, add_s}   = {1'b0, a} + {1'b0, b};
  assign {mul_hi, mul_lo} = {{REG_WIDTH{1'b0}}, a} * {{REG_WIDTH{1'b0}}, b};

  always_comb begin
    ovf = 1'b0;
    case (op)
      ALU_ADD: ovf = add_c;
      ALU_SUB: ovf = (a < b);
      ALU_MUL: ovf = |mul_hi;
      ALU_INC: ovf = &a;
      default: ovf = 1'b0;
    endcase
  end
`else
  assign add_s  = a + b;
  assign mul_lo = a * b;
`endif

  always_comb begin
    result = '0;
    case (op)
      ALU_CLR:  result = '0;
      ALU_PASS: result = b;
      ALU_ADD:  result = add_s;
      ALU_SUB:  result = a - b;
      ALU_MUL:  result = mul_lo;
      ALU_INC:  result = a + ONE;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/core_datapath.sv
// Per-core datapath: register file, shared bus mux, ALU and Z flag.
// ALU_OVF_FLAG_EN adds a registered overflow flag output ovf.
module core_datapath
  import core_datapath_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int IR_WIDTH  = IR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  alu_op_t              aluOp,
  input  inc_reg_t             incReg,
  input  wrEnReg_t             wrEnReg,
  input  bus_in_sel_t          busSel,
  input  logic                 ZWrEn,
  input  logic [IR_WIDTH-1:0]  insMemData,
  input  logic [REG_WIDTH-1:0] dataMemData,
  output logic [REG_WIDTH-1:0] insMemAddr,
  output logic [REG_WIDTH-1:0] dataMemAddr,
  output logic [REG_WIDTH-1:0] dataMemWrData,
  output logic                 Zout
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic                 ovf
`endif
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  logic [REG_WIDTH-1:0] ar_q, r_q, pc_q, rl_q, rc_q, rp_q, rq_q, r1_q, ac_q;
  logic [IR_WIDTH-1:0]  ir_q;
  logic                 z_q;
  logic [REG_WIDTH-1:0] bus;
  logic [REG_WIDTH-1:0] alu_out;

  always_comb begin
    bus = '0;
    case (busSel)
      BUS_DM:  bus = dataMemData;
      BUS_PC:  bus = pc_q;
      BUS_IR:  bus = {{(REG_WIDTH-IR_WIDTH){1'b0}}, ir_q};
      BUS_RL:  bus = rl_q;
      BUS_RC:  bus = rc_q;
      BUS_RP:  bus = rp_q;
      BUS_RQ:  bus = rq_q;
      BUS_R1:  bus = r1_q;
      BUS_AC:  bus = ac_q;
      BUS_R:   bus = r_q;
      default: bus = '0;
    endcase
  end

`ifdef ALU_OVF_FLAG_EN
  logic alu_ovf;
  logic ovf_q;

  core_datapath_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .a      (ac_q),
    .b      (bus),
    .op     (aluOp),
    .result (alu_out),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst)        ovf_q <= 1'b0;
    else if (ZWrEn) ovf_q <= alu_ovf;
  end

  assign ovf = ovf_q;
`else
  core_datapath_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .a      (ac_q),
    .b      (bus),
    .op     (aluOp),
    .result (alu_out)
  );
`endif

  // A write on the same register as an increment takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q <= '0;
      r_q  <= '0;
      pc_q <= '0;
      ir_q <= '0;
      rl_q <= '0;
      rc_q <= '0;
      rp_q <= '0;
      rq_q <= '0;
      r1_q <= '0;
      ac_q <= '0;
      z_q  <= 1'b0;
    end else begin
      if (wrEnReg[WR_AR]) ar_q <= bus;
      if (wrEnReg[WR_R])  r_q  <= bus;
      if (wrEnReg[WR_RL]) rl_q <= bus;
      if (wrEnReg[WR_R1]) r1_q <= bus;
      if (wrEnReg[WR_IR]) ir_q <= insMemData;
      if (wrEnReg[WR_AC]) ac_q <= alu_out;

      if (wrEnReg[WR_PC])      pc_q <= bus;
      else if (incReg[INC_PC]) pc_q <= pc_q + ONE;
      if (wrEnReg[WR_RC])      rc_q <= bus;
      else if (incReg[INC_RC]) rc_q <= rc_q + ONE;
      if (wrEnReg[WR_RP])      rp_q <= bus;
      else if (incReg[INC_RP]) rp_q <= rp_q + ONE;
      if (wrEnReg[WR_RQ])      rq_q <= bus;
      else if (incReg[INC_RQ]) rq_q <= rq_q + ONE;

      if (ZWrEn) z_q <= (alu_out == '0);
    end
  end

  assign insMemAddr    = pc_q;
  assign dataMemAddr   = ar_q;
  assign dataMemWrData = ac_q;
  assign Zout          = z_q;

endmodule

// File: tb/tb_core_datapath.sv
// Self-checking bench for core_datapath against a behavioural register-transfer model.
// Define ALU_OVF_FLAG_EN to also check the overflow flag.
module tb_core_datapath;
  import core_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  alu_op_t     aluOp;
  inc_reg_t    incReg;
  wrEnReg_t    wrEnReg;
  bus_in_sel_t busSel;
  logic        ZWrEn;
  logic [7:0]  insMemData;
  logic [11:0] dataMemData;
  logic [11:0] insMemAddr, dataMemAddr, dataMemWrData;
  logic        Zout;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  core_datapath dut (
    .clk(clk), .rst(rst), .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg),
    .busSel(busSel), .ZWrEn(ZWrEn), .insMemData(insMemData), .dataMemData(dataMemData),
    .insMemAddr(insMemAddr), .dataMemAddr(dataMemAddr), .dataMemWrData(dataMemWrData),
    .Zout(Zout)
`ifdef ALU_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state indexed by write-enable bit position; IR kept zero-extended.
  logic [11:0] mreg [10];
  logic        mz, movf;
  int src_of_sel [10] = '{-1, WR_PC, WR_IR, WR_RL, WR_RC, WR_RP, WR_RQ, WR_R1, WR_AC, WR_R};
  int inc_idx [4]     = '{WR_RQ, WR_RP, WR_RC, WR_PC};

  task automatic model_update(input logic r, input logic [2:0] op, input logic [3:0] inc,
                              input logic [9:0] wen, input logic [3:0] sel, input logic zw,
                              input logic [7:0] ins, input logic [11:0] dm);
    logic [11:0] nxt [10];
    int unsigned a, b, full, res;
    logic ov;
    if (r) begin
      for (int i = 0; i < 10; i++) mreg[i] = '0;
      mz = 1'b0;
      movf = 1'b0;
      return;
    end
    a = mreg[WR_AC];
    if (sel == 4'd0)       b = dm;
    else if (sel <= 4'd9)  b = mreg[src_of_sel[sel]];
    else                   b = 0;
    full = 0;
    case (op)
      3'd1: full = b;
      3'd2: full = a + b;
      3'd3: full = a + 4096 - b;
      3'd4: full = a * b;
      3'd5: full = a + 1;
      default: full = 0;
    endcase
    res = full % 4096;
    ov = (op == 3'd3) ? (a < b) : (full > 4095);
    for (int i = 0; i < 10; i++) nxt[i] = mreg[i];
    for (int k = 0; k < 4; k++)
      if (inc[k]) nxt[inc_idx[k]] = 12'((mreg[inc_idx[k]] + 1) % 4096);
    for (int i = 0; i < 10; i++) begin
      if (wen[i]) begin
        if (i == WR_IR)      nxt[i] = {4'h0, ins};
        else if (i == WR_AC) nxt[i] = 12'(res);
        else                 nxt[i] = 12'(b);
      end
    end
    for (int i = 0; i < 10; i++) mreg[i] = nxt[i];
    if (zw) begin
      mz = (res == 0);
      movf = ov;
    end
  endtask

  task automatic cycle(input logic r, input logic [2:0] op, input logic [3:0] inc,
                       input logic [9:0] wen, input logic [3:0] sel, input logic zw,
                       input logic [7:0] ins, input logic [11:0] dm);
    rst = r;
    aluOp = alu_op_t'(op);
    incReg = inc;
    wrEnReg = wen;
    busSel = bus_in_sel_t'(sel);
    ZWrEn = zw;
    insMemData = ins;
    dataMemData = dm;
    @(posedge clk);
    #1;
    model_update(r, op, inc, wen, sel, zw, ins, dm);
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 4'h0, 10'h000, 4'd0, 1'b0, 8'h00, 12'h000);
  endtask

  task automatic rand_cycle(input int rst_weight);
    cycle(($urandom_range(0, 99) < rst_weight), 3'($urandom_range(0, 5)), 4'($urandom),
          10'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 12'($urandom));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) rand_cycle(0);
    cycle(1'b1, 3'd2, 4'hF, 10'h3FF, 4'd0, 1'b1, 8'hFF, 12'hFFF);
    checks++;
    if (insMemAddr !== 12'h000) begin failures++; $display("FAIL reset_pc got %h want 000", insMemAddr); end
    checks++;
    if (dataMemAddr !== 12'h000) begin failures++; $display("FAIL reset_ar got %h want 000", dataMemAddr); end
    checks++;
    if (dataMemWrData !== 12'h000) begin failures++; $display("FAIL reset_ac got %h want 000", dataMemWrData); end
    checks++;
    if (Zout !== 1'b0) begin failures++; $display("FAIL reset_z got %b want 0", Zout); end
`ifdef ALU_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    for (int s = 1; s <= 9; s++) begin
      cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AR), 4'(s), 1'b0, 8'h00, 12'hABC);
      checks++;
      if (dataMemAddr !== 12'h000) begin
        failures++;
        $display("FAIL reset_reg sel=%0d got %h want 000", s, dataMemAddr);
      end
    end
  endtask

  task automatic test_load_ac();
    cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AC), 4'd0, 1'b1, 8'h00, 12'h00A);
    checks++;
    if (dataMemWrData !== 12'h00A) begin failures++; $display("FAIL load_ac got %h want 00a", dataMemWrData); end
    checks++;
    if (Zout !== 1'b0) begin failures++; $display("FAIL load_ac_z got %b want 0", Zout); end
  endtask

  task automatic test_add_zero();
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_RP), 4'd0, 1'b0, 8'h00, 12'hFFB);
    cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AC), 4'd0, 1'b1, 8'h00, 12'h005);
    cycle(1'b0, 3'd2, 4'h0, 10'(1 << WR_AC), 4'd5, 1'b1, 8'h00, 12'h000);
    checks++;
    if (dataMemWrData !== 12'h000) begin failures++; $display("FAIL add_zero_ac got %h want 000", dataMemWrData); end
    checks++;
    if (Zout !== 1'b1) begin failures++; $display("FAIL add_zero_z got %b want 1", Zout); end
`ifdef ALU_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL add_zero_ovf got %b want 1", ovf); end
`endif
  endtask

  task automatic test_inc_wrap();
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_PC), 4'd0, 1'b0, 8'h00, 12'hFFF);
    cycle(1'b0, 3'd0, 4'(1 << INC_PC), 10'h000, 4'd0, 1'b0, 8'h00, 12'h000);
    checks++;
    if (insMemAddr !== 12'h000) begin failures++; $display("FAIL inc_wrap got %h want 000", insMemAddr); end
    cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AC), 4'd0, 1'b0, 8'h00, 12'h123);
    cycle(1'b0, 3'd0, 4'(1 << INC_PC), 10'(1 << WR_PC), 4'd8, 1'b0, 8'h00, 12'h000);
    checks++;
    if (insMemAddr !== 12'h123) begin failures++; $display("FAIL write_beats_inc got %h want 123", insMemAddr); end
  endtask

  task automatic test_mul();
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_RQ), 4'd0, 1'b0, 8'h00, 12'h080);
    cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AC), 4'd0, 1'b1, 8'h00, 12'h040);
    cycle(1'b0, 3'd4, 4'h0, 10'(1 << WR_AC), 4'd6, 1'b0, 8'h00, 12'h000);
    checks++;
    if (dataMemWrData !== 12'h000) begin failures++; $display("FAIL mul_ac got %h want 000", dataMemWrData); end
    checks++;
    if (Zout !== 1'b0) begin failures++; $display("FAIL mul_z_hold got %b want 0", Zout); end
    cycle(1'b0, 3'd1, 4'h0, 10'(1 << WR_AC), 4'd0, 1'b1, 8'h00, 12'h040);
    cycle(1'b0, 3'd4, 4'h0, 10'(1 << WR_AC), 4'd6, 1'b1, 8'h00, 12'h000);
    checks++;
    if (Zout !== 1'b1) begin failures++; $display("FAIL mul_z_upd got %b want 1", Zout); end
`ifdef ALU_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL mul_ovf got %b want 1", ovf); end
`endif
  endtask

  task automatic test_ir_fetch();
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_IR), 4'd0, 1'b0, 8'h1C, 12'h000);
    cycle(1'b0, 3'd0, 4'h0, 10'((1 << WR_R) | (1 << WR_AR)), 4'd2, 1'b0, 8'hFF, 12'h000);
    checks++;
    if (dataMemAddr !== 12'h01C) begin failures++; $display("FAIL ir_to_ar got %h want 01c", dataMemAddr); end
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_AR), 4'd0, 1'b0, 8'h00, 12'h777);
    cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_AR), 4'd9, 1'b0, 8'h00, 12'h000);
    checks++;
    if (dataMemAddr !== 12'h01C) begin failures++; $display("FAIL ir_to_r got %h want 01c", dataMemAddr); end
  endtask

  task automatic test_illegal_sel();
    for (int s = 10; s <= 15; s++) begin
      cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_AR), 4'd0, 1'b0, 8'h00, 12'h5A5);
      cycle(1'b0, 3'd0, 4'h0, 10'(1 << WR_AR), 4'(s), 1'b0, 8'h00, 12'h5A5);
      checks++;
      if (dataMemAddr !== 12'h000) begin
        failures++;
        $display("FAIL illegal_sel sel=%0d got %h want 000", s, dataMemAddr);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 3'd1, 4'h0, 10'((1 << WR_AC) | (1 << WR_AR) | (1 << WR_PC)), 4'd0, 1'b1, 8'h00, 12'h3C3);
    cycle(1'b1, 3'd1, 4'hF, 10'h3FF, 4'd0, 1'b1, 8'h55, 12'h3C3);
    checks++;
    if ({insMemAddr, dataMemAddr, dataMemWrData} !== 36'h0) begin
      failures++;
      $display("FAIL reset_mid got pc=%h ar=%h ac=%h want 0", insMemAddr, dataMemAddr, dataMemWrData);
    end
    checks++;
    if (Zout !== 1'b0) begin failures++; $display("FAIL reset_mid_z got %b want 0", Zout); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rand_cycle(2);
      checks++;
      if (insMemAddr !== mreg[WR_PC]) begin
        failures++; $display("FAIL rand_pc n=%0d got %h want %h", n, insMemAddr, mreg[WR_PC]);
      end
      checks++;
      if (dataMemAddr !== mreg[WR_AR]) begin
        failures++; $display("FAIL rand_ar n=%0d got %h want %h", n, dataMemAddr, mreg[WR_AR]);
      end
      checks++;
      if (dataMemWrData !== mreg[WR_AC]) begin
        failures++; $display("FAIL rand_ac n=%0d got %h want %h", n, dataMemWrData, mreg[WR_AC]);
      end
      checks++;
      if (Zout !== mz) begin
        failures++; $display("FAIL rand_z n=%0d got %b want %b", n, Zout, mz);
      end
`ifdef ALU_OVF_FLAG_EN
      checks++;
      if (ovf !== movf) begin
        failures++; $display("FAIL rand_ovf n=%0d got %b want %b", n, ovf, movf);
      end
`endif
    end
  endtask

  initial begin
    cycle(1'b1, 3'd0, 4'h0, 10'h000, 4'd0, 1'b0, 8'h00, 12'h000);
    cycle(1'b1, 3'd0, 4'h0, 10'h000, 4'd0, 1'b0, 8'h00, 12'h000);
    test_reset();
    test_load_ac();
    test_add_zero();
    test_inc_wrap();
    test_mul();
    test_ir_fetch();
    test_illegal_sel();
    test_reset_mid();
    test_random();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
